file_mem_burst_initiator: RTL
=============================

// Module: file_mem_burst_initiator
// PURPOSE
//  Initiator for the plusarg file-memory request interface (mem_req_* / mem_resp_data).
//  - Accepts burst commands on a valid/ready port.
//  - Issues one single-beat memory access per cycle, with byte addresses incrementing by DATA_BITS/8.
//  - Takes write data from a valid/ready stream.
//  - Returns read data on a valid/ready stream, buffered by a credit-controlled response FIFO.
//  Sits between DMA/test-harness logic and the file-backed flash/memory model.
// PARAMETERS
//  ADDR_BITS   32  memory byte-address width (<=64)
//  DATA_BITS   64  beat width; 8/16/32/64 only
//  LEN_BITS    8   burst length field; beats = cmd_len+1
//  RESP_DEPTH  2   read-response FIFO entries (>=2)
// PORTS
//  clock          in   1          single clock, rising edge
//  reset_n        in   1          asynchronous, active-low reset
//  cmd_valid      in   1          burst command valid
//  cmd_ready      out  1          command accepted when valid&ready
//  cmd_addr       in   ADDR_BITS  start byte address
//  cmd_len        in   LEN_BITS   beats minus one
//  cmd_r_wb       in   1          1=read burst, 0=write burst
//  wdata_valid    in   1          write beat valid
//  wdata_ready    out  1          write beat consumed when valid&ready
//  wdata          in   DATA_BITS  write beat data
//  rdata_valid    out  1          read beat valid (FIFO head)
//  rdata_ready    in   1          downstream accepts read beat
//  rdata          out  DATA_BITS  read beat data
//  rdata_last     out  1          final beat of the burst
//  mem_req_valid  out  1          memory access this cycle
//  mem_req_addr   out  ADDR_BITS  access address
//  mem_req_data   out  DATA_BITS  write data
//  mem_req_r_wb   out  1          1=read, 0=write
//  mem_resp_data  in   DATA_BITS  read data; valid the cycle after a read request
// BEHAVIOUR
//  Reset
//  - All outputs are 0 except mem_req_r_wb=1.
//  - Reset mid-burst aborts the burst, flushes the FIFO, clears inflight, and returns to IDLE.
//  - cmd_ready=1 from the first cycle after reset_n deasserts.
//  Responder contract
//  - The responder acts every cycle regardless of valid.
//  - mem_req_r_wb MUST be 1 in every cycle except a write beat.
//  - mem_req_data is 0 when not writing; mem_req_addr holds its last value when idle.
//  FSM IDLE -> RD | WR -> (RD: DRAIN) -> IDLE
//  - IDLE: cmd_ready=1. On accept, latch addr, set beats=len+1, go to RD or WR. No cmd_ready in other states.
//  - RD: issue a beat when credit>0, where credit = RESP_DEPTH - fifo_count - inflight + (rdata_valid & rdata_ready).
//    - The rdata_ready -> mem_req_valid combinational path is intended.
//    - inflight is set on issue; mem_resp_data is pushed at the next edge together with the last flag.
//    - After the final issue, go to DRAIN.
//  - DRAIN: wait for inflight=0 and FIFO empty, then go to IDLE.
//  - WR: wdata_ready=1 while beats remain; mem_req_valid=wdata_valid; r_wb=0 only in that cycle.
//    - The final beat goes directly to IDLE (the write commits at that edge).
//  - Throughput: 1 beat/cycle with rdata_ready held or wdata_valid held. Minimum 1 IDLE cycle between bursts.
//  - Address: addr += DATA_BITS/8 per issued beat, modulo 2^ADDR_BITS.
//  - FIFO: never overflows by construction; an overflow/underflow assertion fires in simulation.
// CONFIGURATION
//  FILE_MEM_INIT_WRAP_CHECK_EN
//  - Defined: adds output err_wrap (1).
//    - A command whose addr+(len+1)*DATA_BITS/8 exceeds 2^ADDR_BITS is accepted and issues no beats.
//    - err_wrap pulses 1 cycle later; the block stays in IDLE.
//  - Undefined: no port; addresses wrap silently.
// STRUCTURE
//  - Package file_mem_init_pkg: state_e {IDLE,RD,WR,DRAIN}; function beat_bytes(DATA_BITS); DATA_BITS legality check.
//  - Sub-module file_mem_resp_fifo: {last,data} entries, RESP_DEPTH deep, count output, sync flush, async reset.
// TESTING
//  1 Read addr=0x100 len=3, rdata_ready=1
//    -> reads at 0x100/0x108/0x110/0x118 on consecutive cycles; 4 rdata beats match file; last on the 4th; cmd_ready returns.
//  2 Read len=7, rdata_ready=0 for 10 cycles then 1
//    -> <=RESP_DEPTH requests issued while stalled; all 8 beats delivered in order, none lost.
//  3 Write addr=0x40 len=1, wdata gaps of 3 cycles (0xA5A5..., 0x5A5A...)
//    -> r_wb=0 only in the 2 beat cycles; read-back matches.
//  4 Read addr=0xFFFF_FFF8 len=1
//    -> without macro: addrs 0xFFFF_FFF8 then 0x0.
//    -> with macro: err_wrap pulse, zero mem_req_valid.
//  5 Assert reset_n low mid read burst with FIFO full
//    -> outputs at reset values, rdata_valid=0; a subsequent 1-beat read completes normally.
//  6 Random idle/cmd mix: checker confirms mem_req_r_wb=1 in every non-write-beat cycle.

Source files
------------

// File: rtl/file_mem_init_pkg.sv
// rtl/file_mem_init_pkg.sv - shared state encoding and beat-size helpers for the file-memory burst initiator
package file_mem_init_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Bytes covered by one beat; the address advances by this much per beat.
  function automatic int unsigned beat_bytes(input int unsigned data_bits);
    return data_bits / 8;
  endfunction

  // Beat widths the file-memory model understands.
  function automatic bit data_bits_legal(input int unsigned data_bits);
    return (data_bits == 8) || (data_bits == 16) || (data_bits == 32) || (data_bits == 64);
  endfunction

endpackage

// File: rtl/file_mem_resp_fifo.sv
// rtl/file_mem_resp_fifo.sv - read-response FIFO holding {last,data} entries with occupancy count
module file_mem_resp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] PTR_ONE  = IW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [IW-1:0]    wr_ptr;
  logic [IW-1:0]    rd_ptr;
  logic             full;

  // Status flags and the head entry presented to the consumer.
  always_comb begin
    empty = (count == '0);
    full  = (count == CNT_FULL);
    head  = store[rd_ptr];
  end

  // Entry storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping with wrap for non-power-of-two depths.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // The initiator's credit scheme must keep these from ever happening.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && !flush && full));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && !flush && empty));

endmodule

// File: rtl/file_mem_burst_initiator.sv
// rtl/file_mem_burst_initiator.sv - burst initiator for the file-memory request port (option macro: FILE_MEM_INIT_WRAP_CHECK_EN)
module file_mem_burst_initiator
  import file_mem_init_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 64,
  parameter int LEN_BITS   = 8,
  parameter int RESP_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic                 cmd_r_wb,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_last,
  output logic                 mem_req_valid,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [DATA_BITS-1:0] mem_req_data,
  output logic                 mem_req_r_wb,
  input  logic [DATA_BITS-1:0] mem_resp_data
`ifdef FILE_MEM_INIT_WRAP_CHECK_EN
  ,
  output logic                 err_wrap
`endif
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RD    = RD;
  localparam logic [1:0] S_WR    = WR;
  localparam logic [1:0] S_DRAIN = DRAIN;

  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [ADDR_BITS-1:0] ADDR_STEP   = ADDR_BITS'(beat_bytes(DATA_BITS));
  localparam logic [CW:0]          DEPTH_SLOTS = CW1'(RESP_DEPTH);
  localparam logic [LEN_BITS:0]    BEAT_ONE    = {{LEN_BITS{1'b0}}, 1'b1};

  if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
    $error("DATA_BITS must be 8, 16, 32 or 64");
  end

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS:0]    beats_q;
  logic                 inflight_q;
  logic                 inflight_last_q;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic [DATA_BITS:0]   fifo_head;

  logic                 cmd_accept;
  logic                 rd_pop;
  logic [CW:0]          used_slots;
  logic                 credit_ok;
  logic                 last_beat;
  logic                 rd_issue;
  logic                 wr_beat;
  logic                 wrap_bad;

  // Handshakes, credit and request-port drive; rdata_ready reaches mem_req_valid combinationally
  // so a popping consumer frees a slot in the same cycle and sustains one beat per cycle.
  always_comb begin
    // reset_n gating keeps cmd_ready low while reset is held and high straight after release.
    cmd_ready     = reset_n && (state == S_IDLE);
    cmd_accept    = cmd_valid && cmd_ready;
    rdata_valid   = !fifo_empty;
    rd_pop        = rdata_valid && rdata_ready;
    used_slots    = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    credit_ok     = used_slots < (DEPTH_SLOTS + {{CW{1'b0}}, rd_pop});
    last_beat     = (beats_q == BEAT_ONE);
    rd_issue      = (state == S_RD) && credit_ok;
    wr_beat       = (state == S_WR) && wdata_valid;
    wdata_ready   = (state == S_WR);
    mem_req_valid = rd_issue || wr_beat;
    mem_req_r_wb  = !wr_beat;
    mem_req_data  = wr_beat ? wdata : '0;
    mem_req_addr  = addr_q;
    rdata         = rdata_valid ? fifo_head[DATA_BITS-1:0] : '0;
    rdata_last    = rdata_valid && fifo_head[DATA_BITS];
  end

`ifdef FILE_MEM_INIT_WRAP_CHECK_EN
  localparam int EW = ADDR_BITS + LEN_BITS + 5;
  logic [EW-1:0] burst_end;

  // Flag commands whose last byte would land beyond the top of the address space.
  always_comb begin
    burst_end = EW'(cmd_addr) + EW'({1'b0, cmd_len} + BEAT_ONE) * EW'(beat_bytes(DATA_BITS));
    wrap_bad  = burst_end > (EW'(1) << ADDR_BITS);
  end

  // One-cycle error pulse for a rejected wrapping command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_wrap <= 1'b0;
    end else begin
      err_wrap <= cmd_accept && wrap_bad;
    end
  end
`else
  assign wrap_bad = 1'b0;
`endif

  // Burst sequencing: latch the command, step address/beat count per issued beat.
  // addr_q is not advanced on the final beat so the request address rests on the last access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      addr_q          <= '0;
      beats_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && last_beat;
      case (state)
        S_IDLE: begin
          if (cmd_accept && !wrap_bad) begin
            addr_q  <= cmd_addr;
            beats_q <= {1'b0, cmd_len} + BEAT_ONE;
            state   <= cmd_r_wb ? S_RD : S_WR;
          end
        end
        S_RD: begin
          if (rd_issue) begin
            beats_q <= beats_q - BEAT_ONE;
            if (last_beat) begin
              state <= S_DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_STEP;
            end
          end
        end
        S_WR: begin
          if (wr_beat) begin
            beats_q <= beats_q - BEAT_ONE;
            if (last_beat) begin
              state <= S_IDLE;
            end else begin
              addr_q <= addr_q + ADDR_STEP;
            end
          end
        end
        S_DRAIN: begin
          if (!inflight_q && fifo_empty) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data returns one cycle after issue and is captured together with its last flag.
  file_mem_resp_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (cmd_accept),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_resp_data}),
    .pop       (rd_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
